execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
Y86-64 execute stage. It sits directly downstream of the decode stage and consumes the 217-bit execute_reg bundle that decode produces. It computes valE with the ALU, evaluates the branch/cmov condition, and owns the condition-code register. It drives the forwarding signals e_dstE/e_valE back to decode and registers its results into the 142-bit memory_reg for the memory stage, with stall/bubble control.

Parameters:
XLEN, 64, datapath width (fixed at 64; widths below assume it)
RNONE, 4'hF, "no register" encoding

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
execute_reg  in  217  from decode: [216] stat_err, [215:212] icode, [211:208] ifun, [207:144] valC, [143:80] valA, [79:16] valB, [15:12] dstE, [11:8] dstM, [7:4] srcA, [3:0] srcB
m_stat_err  in  1  exception in memory stage (blocks CC update)
W_stat_err  in  1  exception in writeback stage (blocks CC update)
M_stall  in  1  hold memory_reg
M_bubble  in  1  load NOP bubble into memory_reg
e_dstE  out  4  combinational forwarding destination
e_valE  out  64  combinational ALU result
e_Cnd  out  1  combinational condition result (to branch-mispredict logic)
cc  out  3  registered condition codes {ZF,SF,OF}
memory_reg  out  142  [141] stat_err, [140:137] icode, [136] Cnd, [135:72] valE, [71:8] valA, [7:4] dstE, [3:0] dstM

Behaviour:
- Reset (async, rst_n=0): cc=3'b100 (ZF=1, SF=0, OF=0); memory_reg = bubble (icode=1 NOP, dstE=dstM=RNONE, all other fields 0). Deasserting rst_n mid-stream discards any in-flight result; the first edge after release captures the current execute_reg.
- aluA: valA for icode 2 (rrmovq/cmov) and 6 (OPq); valC for 3, 4, 5; -8 for 8 (call) and 10 (push); +8 for 9 (ret) and 11 (pop); 0 otherwise.
- aluB: valB for icode 4, 5, 6, 8, 9, 10, 11; 0 otherwise.
- ALU function: for icode 6, ifun selects 0 = add B+A, 1 = sub B-A, 2 = and, 3 = xor; ifun>3 yields 0. All other icodes use add. Arithmetic is 64-bit modulo with no carry out.
- e_valE = ALU result (combinational, same cycle as execute_reg is valid).
- Flags from the result r: ZF = (r==0); SF = r[63].
  - add: OF = (A[63]==B[63]) && (r[63]!=B[63]).
  - sub: OF = (A[63]!=B[63]) && (r[63]!=B[63]).
  - and/xor: OF = 0.
- CC update on a rising edge only when icode==6, execute_reg[216]==0, m_stat_err==0 and W_stat_err==0. CC is otherwise held. CC is not affected by M_stall or M_bubble.
- e_Cnd is computed from the current registered cc and ifun:
  - 0 always=1
  - 1 le=(SF^OF)|ZF
  - 2 l=SF^OF
  - 3 e=ZF
  - 4 ne=!ZF
  - 5 ge=!(SF^OF)
  - 6 g=!(SF^OF)&!ZF
  - >6 = 0
  - e_Cnd is meaningful for icode 2 and 7; it is forced to 0 for every other icode.
- e_dstE = RNONE when icode==2 and e_Cnd==0 (cmov not taken); otherwise execute_reg[15:12].
- memory_reg update on the rising edge:
  - M_stall=1: hold. Stall wins over bubble when both are asserted.
  - else M_bubble=1: load the bubble value.
  - else load {stat_err, icode, e_Cnd, e_valE, valA, e_dstE, dstM}.
- Latency: one cycle from execute_reg to memory_reg; forwarding outputs have zero cycles of latency.
- An OPq immediately followed by a jump/cmov uses the updated cc, because the CC register is written at the same edge that advances the pipeline.

Test Plan:
- Reset: assert rst_n=0 mid-run -> cc=100 and memory_reg icode=1, dstE=dstM=F immediately, with no clock edge required.
- OPq add (icode 6, ifun 0), valA=5, valB=-5 (0xFFFF_FFFF_FFFF_FFFB), dstE=3 -> e_valE=0, e_dstE=3; after the edge cc=100 and memory_reg valE=0.
- OPq sub, valA=1, valB=0x8000_0000_0000_0000 -> e_valE=0x7FFF_FFFF_FFFF_FFFF, cc=001 (OF=1). Repeat with m_stat_err=1 -> cc unchanged.
- cmovle (icode 2, ifun 1) with cc=000 -> e_Cnd=0, e_dstE=F. Then with cc=100 -> e_Cnd=1, e_dstE=execute_reg dstE, e_valE=valA.
- pushq (icode 10), valB=0x100 -> e_valE=0xF8, e_dstE=4. popq (icode 11), valB=0x100 -> e_valE=0x108.
- Pipeline control: hold M_stall=1 for 2 cycles while execute_reg changes -> memory_reg unchanged. Then M_bubble=1 -> NOP bubble. M_stall=M_bubble=1 -> hold.

Source files
------------

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : Y86-64 execute stage. ALU, branch/cmov condition evaluation,
//                condition-code register, forwarding outputs and the
//                memory_reg pipeline register with stall/bubble control.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
    parameter int         XLEN  = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [216:0]      execute_reg,
    input  logic              m_stat_err,
    input  logic              W_stat_err,
    input  logic              M_stall,
    input  logic              M_bubble,
    output logic [3:0]        e_dstE,
    output logic [XLEN-1:0]   e_valE,
    output logic              e_Cnd,
    output logic [2:0]        cc,
    output logic [141:0]      memory_reg
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam logic [141:0] BUBBLE = {1'b0, I_NOP, 1'b0, {XLEN{1'b0}}, {XLEN{1'b0}}, RNONE, RNONE};

    // Field extraction from the decode bundle
    logic            stat_err;
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [XLEN-1:0] valC;
    logic [XLEN-1:0] valA;
    logic [XLEN-1:0] valB;
    logic [3:0]      dstE;
    logic [3:0]      dstM;
    logic            unused_src;

    assign stat_err   = execute_reg[216];
    assign icode      = execute_reg[215:212];
    assign ifun       = execute_reg[211:208];
    assign valC       = execute_reg[207:144];
    assign valA       = execute_reg[143:80];
    assign valB       = execute_reg[79:16];
    assign dstE       = execute_reg[15:12];
    assign dstM       = execute_reg[11:8];
    // srcA/srcB only matter to decode's forwarding logic
    assign unused_src = ^execute_reg[7:0];

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_r;
    logic            alu_of;
    logic [2:0]      cc_next;
    logic            cc_write;
    logic            zf;
    logic            sf;
    logic            of;
    logic            cond_raw;

    // ALU operand A selection by instruction class
    always_comb begin
        alu_a = '0;
        case (icode)
            I_RRMOVQ, I_OPQ:            alu_a = valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC;
            I_CALL, I_PUSHQ:            alu_a = -64'sd8;
            I_RET, I_POPQ:              alu_a = 64'd8;
            default:                    alu_a = '0;
        endcase
    end

    // ALU operand B selection by instruction class
    always_comb begin
        alu_b = '0;
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB;
            default: alu_b = '0;
        endcase
    end

    // ALU: only OPq chooses a function; everything else is an address/move add
    always_comb begin
        alu_r  = '0;
        alu_of = 1'b0;
        if (icode != I_OPQ) begin
            alu_r  = alu_b + alu_a;
            alu_of = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (alu_r[XLEN-1] != alu_b[XLEN-1]);
        end else if (ifun[3:2] == 2'b00) begin
            case (ifun[1:0])
                ALU_ADD: begin
                    alu_r  = alu_b + alu_a;
                    alu_of = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (alu_r[XLEN-1] != alu_b[XLEN-1]);
                end
                ALU_SUB: begin
                    alu_r  = alu_b - alu_a;
                    alu_of = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (alu_r[XLEN-1] != alu_b[XLEN-1]);
                end
                ALU_AND: alu_r = alu_b & alu_a;
                default: alu_r = alu_b ^ alu_a;
            endcase
        end
    end

    assign e_valE   = alu_r;
    assign cc_next  = {(alu_r == '0), alu_r[XLEN-1], alu_of};
    assign cc_write = (icode == I_OPQ) && !stat_err && !m_stat_err && !W_stat_err;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    // Condition evaluation against the currently registered flags
    always_comb begin
        cond_raw = 1'b0;
        case (ifun)
            4'd0:    cond_raw = 1'b1;
            4'd1:    cond_raw = (sf ^ of) | zf;
            4'd2:    cond_raw = sf ^ of;
            4'd3:    cond_raw = zf;
            4'd4:    cond_raw = !zf;
            4'd5:    cond_raw = !(sf ^ of);
            4'd6:    cond_raw = !(sf ^ of) && !zf;
            default: cond_raw = 1'b0;
        endcase
    end

    assign e_Cnd  = ((icode == I_RRMOVQ) || (icode == I_JXX)) ? cond_raw : 1'b0;
    assign e_dstE = ((icode == I_RRMOVQ) && !e_Cnd) ? RNONE : dstE;

    // Condition-code register: written only by OPq with no exception downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= 3'b100;
        end else if (cc_write) begin
            cc <= cc_next;
        end
    end

    // memory_reg pipeline register; stall takes priority over bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memory_reg <= BUBBLE;
        end else if (M_stall) begin
            memory_reg <= memory_reg;
        end else if (M_bubble) begin
            memory_reg <= BUBBLE;
        end else begin
            memory_reg <= {stat_err, icode, e_Cnd, e_valE, valA, e_dstE, dstM};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Scoreboard bench for execute_stage. Stimulus pushes the
//                hand-computed expectation for each cycle; a monitor pops
//                and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [216:0] execute_reg;
    logic         m_stat_err;
    logic         W_stat_err;
    logic         M_stall;
    logic         M_bubble;
    logic [3:0]   e_dstE;
    logic [63:0]  e_valE;
    logic         e_Cnd;
    logic [2:0]   cc;
    logic [141:0] memory_reg;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        name;
        logic [63:0]  valE;
        logic [3:0]   dstE;
        logic         cnd;
        logic [2:0]   cc;
        logic [141:0] mreg;
    } exp_t;

    exp_t sb_q[$];

    execute_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .execute_reg(execute_reg),
        .m_stat_err (m_stat_err),
        .W_stat_err (W_stat_err),
        .M_stall    (M_stall),
        .M_bubble   (M_bubble),
        .e_dstE     (e_dstE),
        .e_valE     (e_valE),
        .e_Cnd      (e_Cnd),
        .cc         (cc),
        .memory_reg (memory_reg)
    );

    always #5 clk = ~clk;

    localparam logic [141:0] BUB = {1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF};

    function automatic logic [216:0] ereg(input logic st, input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                                          input logic [3:0] de, input logic [3:0] dm);
        return {st, ic, fn, vc, va, vb, de, dm, 4'hF, 4'hF};
    endfunction

    function automatic logic [141:0] mr(input logic st, input logic [3:0] ic, input logic cn,
                                        input logic [63:0] ve, input logic [63:0] va,
                                        input logic [3:0] de, input logic [3:0] dm);
        return {st, ic, cn, ve, va, de, dm};
    endfunction

    task automatic check(input string name, input logic [141:0] act, input logic [141:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the expectation for that cycle:
    // comb outputs for the inputs driven now, registered outputs from the prior edge
    task automatic step(input string name, input logic [216:0] er,
                        input logic me, input logic we, input logic st, input logic bb,
                        input logic [63:0] x_valE, input logic [3:0] x_dstE, input logic x_cnd,
                        input logic [2:0] x_cc, input logic [141:0] x_mreg);
        exp_t e;
        @(posedge clk);
        #1;
        execute_reg = er;
        m_stat_err  = me;
        W_stat_err  = we;
        M_stall     = st;
        M_bubble    = bb;
        e.name = name; e.valE = x_valE; e.dstE = x_dstE; e.cnd = x_cnd; e.cc = x_cc; e.mreg = x_mreg;
        sb_q.push_back(e);
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, ".valE"}, {78'b0, e_valE}, {78'b0, e.valE});
            check({e.name, ".dstE"}, {138'b0, e_dstE}, {138'b0, e.dstE});
            check({e.name, ".Cnd"},  {141'b0, e_Cnd}, {141'b0, e.cnd});
            check({e.name, ".cc"},   {139'b0, cc}, {139'b0, e.cc});
            check({e.name, ".mreg"}, memory_reg, e.mreg);
        end
    end

    localparam logic [63:0] NEG5  = 64'hFFFF_FFFF_FFFF_FFFB;
    localparam logic [63:0] MIN   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXP  = 64'h7FFF_FFFF_FFFF_FFFF;

    initial begin
        rst_n       = 1'b0;
        execute_reg = ereg(0, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF);
        m_stat_err  = 0; W_stat_err = 0; M_stall = 0; M_bubble = 0;
        repeat (2) @(posedge clk);
        #2;
        check("reset.cc",   {139'b0, cc}, {139'b0, 3'b100});
        check("reset.mreg", memory_reg, BUB);
        #1 rst_n = 1'b1;

        //   name      execute_reg                                         me we st bb  valE            dstE  cnd  cc      memory_reg (from previous edge)
        step("add0",   ereg(0,4'h6,0,0,64'd5,NEG5,4'h3,4'hF),              0, 0, 0, 0, 64'h0,          4'h3, 0, 3'b100, BUB);
        step("subMerr",ereg(0,4'h6,1,0,64'd1,MIN,4'h4,4'hF),               1, 0, 0, 0, MAXP,           4'h4, 0, 3'b100, mr(0,4'h6,0,64'h0,64'd5,4'h3,4'hF));
        step("subOF",  ereg(0,4'h6,1,0,64'd1,MIN,4'h4,4'hF),               0, 0, 0, 0, MAXP,           4'h4, 0, 3'b100, mr(0,4'h6,0,MAXP,64'd1,4'h4,4'hF));
        step("addWerr",ereg(0,4'h6,0,0,64'd1,64'd1,4'h3,4'hF),             0, 1, 0, 0, 64'd2,          4'h3, 0, 3'b001, mr(0,4'h6,0,MAXP,64'd1,4'h4,4'hF));
        step("addPos", ereg(0,4'h6,0,0,64'd1,64'd1,4'h3,4'hF),             0, 0, 0, 0, 64'd2,          4'h3, 0, 3'b001, mr(0,4'h6,0,64'd2,64'd1,4'h3,4'hF));
        step("cmovNT", ereg(0,4'h2,1,0,64'h1234,0,4'h5,4'hF),              0, 0, 0, 0, 64'h1234,       4'hF, 0, 3'b000, mr(0,4'h6,0,64'd2,64'd1,4'h3,4'hF));
        step("xorZ",   ereg(0,4'h6,3,0,64'hAA,64'hAA,4'h6,4'hF),           0, 0, 0, 0, 64'h0,          4'h6, 0, 3'b000, mr(0,4'h2,0,64'h1234,64'h1234,4'hF,4'hF));
        step("cmovT",  ereg(0,4'h2,1,0,64'h1234,0,4'h5,4'hF),              0, 0, 0, 0, 64'h1234,       4'h5, 1, 3'b100, mr(0,4'h6,0,64'h0,64'hAA,4'h6,4'hF));
        step("push",   ereg(0,4'hA,0,0,64'h55,64'h100,4'h4,4'hF),          0, 0, 0, 0, 64'hF8,         4'h4, 0, 3'b100, mr(0,4'h2,1,64'h1234,64'h1234,4'h5,4'hF));
        step("pop",    ereg(0,4'hB,0,0,64'h100,64'h100,4'h4,4'h7),         0, 0, 0, 0, 64'h108,        4'h4, 0, 3'b100, mr(0,4'hA,0,64'hF8,64'h55,4'h4,4'hF));
        step("je",     ereg(0,4'h7,3,64'h400,0,0,4'hF,4'hF),               0, 0, 0, 0, 64'h0,          4'hF, 1, 3'b100, mr(0,4'hB,0,64'h108,64'h100,4'h4,4'h7));
        step("stall1", ereg(0,4'h3,0,64'h77,0,0,4'h2,4'hF),                0, 0, 1, 0, 64'h77,         4'h2, 0, 3'b100, mr(0,4'h7,1,64'h0,64'h0,4'hF,4'hF));
        step("stall2", ereg(0,4'h3,0,64'h99,0,0,4'h2,4'hF),                0, 0, 1, 0, 64'h99,         4'h2, 0, 3'b100, mr(0,4'h7,1,64'h0,64'h0,4'hF,4'hF));
        step("bubble", ereg(0,4'h3,0,64'h99,0,0,4'h2,4'hF),                0, 0, 0, 1, 64'h99,         4'h2, 0, 3'b100, mr(0,4'h7,1,64'h0,64'h0,4'hF,4'hF));
        step("stlbub", ereg(0,4'h3,0,64'h33,0,0,4'h1,4'hF),                0, 0, 1, 1, 64'h33,         4'h1, 0, 3'b100, BUB);
        step("staterr",ereg(1,4'h3,0,64'h33,0,0,4'h1,4'hF),                0, 0, 0, 0, 64'h33,         4'h1, 0, 3'b100, BUB);
        step("andErr", ereg(1,4'h6,2,0,64'hF0,64'h3C,4'h7,4'hF),           0, 0, 0, 0, 64'h30,         4'h7, 0, 3'b100, mr(1,4'h3,0,64'h33,64'h0,4'h1,4'hF));
        step("and",    ereg(0,4'h6,2,0,64'hF0,64'h3C,4'h7,4'hF),           0, 0, 0, 0, 64'h30,         4'h7, 0, 3'b100, mr(1,4'h6,0,64'h30,64'hF0,4'h7,4'hF));
        step("nop",    ereg(0,4'h1,0,0,0,0,4'hF,4'hF),                     0, 0, 0, 0, 64'h0,          4'hF, 0, 3'b000, mr(0,4'h6,0,64'h30,64'hF0,4'h7,4'hF));

        // Let the monitor drain, then reset asynchronously away from any edge
        @(negedge clk);
        #2;
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        rst_n = 1'b0;
        #1;
        check("async_rst.cc",   {139'b0, cc}, {139'b0, 3'b100});
        check("async_rst.mreg", memory_reg, BUB);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
